// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared constants and default sizing for the hazard scoreboard.
// Revision : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int         DEFAULT_NREGS    = 32;
  localparam int         DEFAULT_MAX_PEND = 4;
  localparam logic [1:0] RESULT_SRC_LOAD  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : Pipeline-side bundle between datapath (master) and scoreboard (slave).
// Revision : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int RW       = $clog2(NREGS),
  parameter int MAX_PEND = DEFAULT_MAX_PEND,
  parameter int PW       = $clog2(MAX_PEND + 1)
);

  logic [1:0]       resultSrcE;
  logic             branchTakenE;
  logic [RW-1:0]    rdE;
  logic             issueLongE;
  logic [RW-1:0]    rs1D;
  logic [RW-1:0]    rs2D;
  logic [RW-1:0]    rdD;
  logic             useRs1D;
  logic             useRs2D;
  logic             longD;
  logic             wbValid;
  logic [RW-1:0]    wbRd;
  logic             pc_write;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [NREGS-1:0] busy_vec;
  logic [PW-1:0]    pend_cnt;

  modport master (
    output resultSrcE, branchTakenE, rdE, issueLongE,
    output rs1D, rs2D, rdD, useRs1D, useRs2D, longD,
    output wbValid, wbRd,
    input  pc_write, stallF, stallD, flushD, flushE, busy_vec, pend_cnt
  );

  modport slave (
    input  resultSrcE, branchTakenE, rdE, issueLongE,
    input  rs1D, rs2D, rdD, useRs1D, useRs2D, longD,
    input  wbValid, wbRd,
    output pc_write, stallF, stallD, flushD, flushE, busy_vec, pend_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_sat_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_updown_counter
// Brief    : Up/down counter saturating at 0 and MAX; simultaneous inc+dec holds.
// Revision : 1.0  initial release
// ============================================================================
module sat_updown_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX_V)) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Load-use / long-latency scoreboard hazard unit with branch flush.
//            Optional HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int RW       = $clog2(NREGS),
  parameter int MAX_PEND = DEFAULT_MAX_PEND,
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_eff;
  logic [PW-1:0]    w_pend;
  logic             w_issue;
  logic             w_load_use;
  logic             w_sb_haz;
  logic             w_full_haz;
  logic             w_stall;

  assign w_issue = hz.issueLongE && (hz.rdE != '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_busy_bit
    assign w_clr[r] = hz.wbValid && (hz.wbRd == RW'(r));
    assign w_set[r] = w_issue && (hz.rdE == RW'(r));
  end

  // A completing writeback is visible to D in the same cycle, so it masks its own busy bit.
  assign w_busy_eff = busy_q & ~w_clr;
  assign busy_d     = (w_busy_eff | w_set) & ~NREGS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  sat_updown_counter #(
    .WIDTH (PW),
    .MAX   (MAX_PEND)
  ) u_pend_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_issue),
    .dec   (hz.wbValid),
    .count (w_pend)
  );

  assign w_load_use = (hz.resultSrcE == RESULT_SRC_LOAD) && (hz.rdE != '0) &&
                      ((hz.useRs1D && (hz.rdE == hz.rs1D)) ||
                       (hz.useRs2D && (hz.rdE == hz.rs2D)));

  assign w_sb_haz   = (hz.useRs1D && w_busy_eff[hz.rs1D]) ||
                      (hz.useRs2D && w_busy_eff[hz.rs2D]) ||
                      ((hz.rdD != '0) && w_busy_eff[hz.rdD]);

  assign w_full_haz = hz.longD && (w_pend == PW'(MAX_PEND)) && !hz.wbValid;
  assign w_stall    = w_load_use || w_sb_haz || w_full_haz;

  // A taken branch squashes both younger stages, so stalling them is pointless.
  assign hz.pc_write = hz.branchTakenE ? 1'b1 : !w_stall;
  assign hz.stallF   = hz.branchTakenE ? 1'b0 : w_stall;
  assign hz.stallD   = hz.branchTakenE ? 1'b0 : w_stall;
  assign hz.flushD   = hz.branchTakenE;
  assign hz.flushE   = hz.branchTakenE || w_stall;
  assign hz.busy_vec = busy_q;
  assign hz.pend_cnt = w_pend;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall && !hz.branchTakenE) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (hz.branchTakenE) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int NREGS    = 32;
  localparam int RW       = 5;
  localparam int MAX_PEND = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREGS(NREGS), .RW(RW), .MAX_PEND(MAX_PEND)) hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_scoreboard #(
    .NREGS    (NREGS),
    .RW       (RW),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     m_busy[NREGS];
  int     m_pend;
  longint m_stall_cnt;
  longint m_flush_cnt;

  typedef struct {
    logic [1:0] rsrc;
    logic       br;
    logic [4:0] rdE;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rdD;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] exp;   // {pc_write, stallF, stallD, flushD, flushE}
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hz.resultSrcE = 2'b00; hz.branchTakenE = 1'b0; hz.rdE = '0; hz.issueLongE = 1'b0;
    hz.rs1D = '0; hz.rs2D = '0; hz.rdD = '0; hz.useRs1D = 1'b0; hz.useRs2D = 1'b0;
    hz.longD = 1'b0; hz.wbValid = 1'b0; hz.wbRd = '0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    m_pend = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  function automatic bit model_stall();
    bit eff[NREGS];
    bit lu, sb, full;
    for (int r = 0; r < NREGS; r++)
      eff[r] = m_busy[r] && !(hz.wbValid && (int'(hz.wbRd) == r));
    lu = (hz.resultSrcE == 2'b01) && (hz.rdE != 0) &&
         ((hz.useRs1D && hz.rdE == hz.rs1D) || (hz.useRs2D && hz.rdE == hz.rs2D));
    sb = (hz.useRs1D && eff[hz.rs1D]) || (hz.useRs2D && eff[hz.rs2D]) ||
         (hz.rdD != 0 && eff[hz.rdD]);
    full = hz.longD && (m_pend == MAX_PEND) && !hz.wbValid;
    return lu || sb || full;
  endfunction

  function automatic logic [4:0] model_ctl();
    bit st;
    st = model_stall();
    if (hz.branchTakenE) return 5'b10011;
    return {!st, st, st, 1'b0, st};
  endfunction

  function automatic logic [NREGS-1:0] model_busy_vec();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_update();
    bit st, inc, dec;
    st  = model_stall();
    inc = hz.issueLongE && (hz.rdE != 0);
    dec = hz.wbValid;
    if (dec) m_busy[hz.wbRd] = 1'b0;
    if (inc) m_busy[hz.rdE]  = 1'b1;
    if (inc && !dec && m_pend < MAX_PEND) m_pend++;
    if (dec && !inc && m_pend > 0)        m_pend--;
    if (st && !hz.branchTakenE) m_stall_cnt++;
    if (hz.branchTakenE)        m_flush_cnt++;
  endtask

  function automatic logic [4:0] ctl_now();
    return {hz.pc_write, hz.stallF, hz.stallD, hz.flushD, hz.flushE};
  endfunction

  // One clock: controls checked mid-cycle, state checked just after the edge.
  task automatic cycle(input string tag, output logic [4:0] seen);
    @(negedge clk);
    seen = ctl_now();
    chk({tag, "/ctl"}, seen, model_ctl());
    @(posedge clk);
    model_update();
    #1;
    chk({tag, "/busy_vec"}, hz.busy_vec, model_busy_vec());
    chk({tag, "/pend_cnt"}, hz.pend_cnt, m_pend);
`ifdef HAZARD_PERF_EN
    chk({tag, "/stall_cnt"}, stall_cnt, m_stall_cnt);
    chk({tag, "/flush_cnt"}, flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset/ctl", ctl_now(), 5'b10000);
    chk("reset/busy_vec", hz.busy_vec, 0);
    chk("reset/pend_cnt", hz.pend_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s;

    //              rsrc  br  rdE rs1 rs2 rdD u1 u2 ld  exp
    tbl[0] = '{2'b00, 1'b0, 5'd4, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[1] = '{2'b01, 1'b0, 5'd4, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b01101};
    tbl[2] = '{2'b01, 1'b0, 5'd6, 5'd1, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 5'b01101};
    tbl[3] = '{2'b01, 1'b0, 5'd4, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10000};
    tbl[4] = '{2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[5] = '{2'b10, 1'b0, 5'd4, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[6] = '{2'b01, 1'b1, 5'd4, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b10011};
    tbl[7] = '{2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10011};
    tbl[8] = '{2'b00, 1'b0, 5'd0, 5'd3, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'b10000};
    tbl[9] = '{2'b01, 1'b0, 5'd9, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 5'b10000};

    idle();
    model_clear();
    apply_reset();

    for (int i = 0; i < 10; i++) begin
      idle();
      hz.resultSrcE = tbl[i].rsrc; hz.branchTakenE = tbl[i].br; hz.rdE = tbl[i].rdE;
      hz.rs1D = tbl[i].rs1; hz.rs2D = tbl[i].rs2; hz.rdD = tbl[i].rdD;
      hz.useRs1D = tbl[i].u1; hz.useRs2D = tbl[i].u2; hz.longD = tbl[i].ld;
      cycle($sformatf("vec%0d", i), s);
      chk($sformatf("vec%0d/expected", i), s, tbl[i].exp);
    end

    // Scoreboard RAW on a long op, released by its writeback
    apply_reset();
    idle(); hz.issueLongE = 1'b1; hz.rdE = 5'd7;
    cycle("sb_issue", s);
    idle(); hz.rs2D = 5'd7; hz.useRs2D = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle("sb_wait", s);
      chk("sb_wait/stall", s, 5'b01101);
    end
    hz.wbValid = 1'b1; hz.wbRd = 5'd7;
    cycle("sb_wb", s);
    chk("sb_wb/no_stall", s, 5'b10000);
    chk("sb_wb/busy7", hz.busy_vec[7], 1'b0);

    // Issue to x0 changes nothing; writeback on empty counter saturates at 0
    apply_reset();
    idle(); hz.issueLongE = 1'b1; hz.rdE = 5'd0;
    cycle("x0_issue", s);
    chk("x0_issue/busy_vec", hz.busy_vec, 0);
    chk("x0_issue/pend_cnt", hz.pend_cnt, 0);
    idle(); hz.wbValid = 1'b1; hz.wbRd = 5'd3;
    cycle("sat_min", s);
    chk("sat_min/pend_cnt", hz.pend_cnt, 0);

    // Fill the pending window
    for (int i = 1; i <= 4; i++) begin
      idle(); hz.issueLongE = 1'b1; hz.rdE = 5'(i);
      cycle($sformatf("fill%0d", i), s);
    end
    chk("full/pend_cnt", hz.pend_cnt, 4);
    idle(); hz.longD = 1'b1;
    cycle("full_stall", s);
    chk("full_stall/ctl", s, 5'b01101);
    hz.wbValid = 1'b1; hz.wbRd = 5'd1; hz.issueLongE = 1'b1; hz.rdE = 5'd5;
    cycle("full_wb", s);
    chk("full_wb/ctl", s, 5'b10000);
    chk("full_wb/pend_cnt", hz.pend_cnt, 4);
    idle(); hz.issueLongE = 1'b1; hz.rdE = 5'd6;
    cycle("sat_max", s);
    chk("sat_max/pend_cnt", hz.pend_cnt, 4);

    // Same-cycle set and clear of one register
    apply_reset();
    idle(); hz.issueLongE = 1'b1; hz.rdE = 5'd9;
    cycle("sc_issue", s);
    hz.wbValid = 1'b1; hz.wbRd = 5'd9;
    cycle("sc_both", s);
    chk("sc_both/busy9", hz.busy_vec[9], 1'b1);

    // Asynchronous reset while stalled
    idle(); hz.rs1D = 5'd9; hz.useRs1D = 1'b1;
    @(negedge clk);
    chk("rst_mid/pre_stall", hz.stallF, 1'b1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_mid/busy_vec", hz.busy_vec, 0);
    chk("rst_mid/pend_cnt", hz.pend_cnt, 0);
    chk("rst_mid/ctl", ctl_now(), 5'b10000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("rst_mid/after", s);
    chk("rst_mid/after_ctl", s, 5'b10000);

`ifdef HAZARD_PERF_EN
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      idle(); hz.resultSrcE = 2'b01; hz.rdE = 5'd4; hz.rs1D = 5'd4; hz.useRs1D = 1'b1;
      cycle("perf_stall", s);
    end
    for (int k = 0; k < 2; k++) begin
      idle(); hz.branchTakenE = 1'b1;
      cycle("perf_branch", s);
    end
    chk("perf/stall_cnt", stall_cnt, 3);
    chk("perf/flush_cnt", flush_cnt, 2);
`endif

    // Randomized traffic against the reference model
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      hz.resultSrcE   = 2'($urandom_range(0, 3));
      hz.branchTakenE = ($urandom_range(0, 9) == 0);
      hz.rdE          = 5'($urandom_range(0, 7));
      hz.issueLongE   = ($urandom_range(0, 9) < 4);
      hz.rs1D         = 5'($urandom_range(0, 7));
      hz.rs2D         = 5'($urandom_range(0, 7));
      hz.rdD          = 5'($urandom_range(0, 7));
      hz.useRs1D      = 1'($urandom_range(0, 1));
      hz.useRs2D      = 1'($urandom_range(0, 1));
      hz.longD        = 1'($urandom_range(0, 1));
      hz.wbValid      = ($urandom_range(0, 9) < 3);
      hz.wbRd         = 5'($urandom_range(0, 7));
      cycle("rand", s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, 32, number of architectural registers.
REQ-002 SHALL have parameter RW, 5, register-index width, equal to clog2(NREGS).
REQ-003 SHALL have parameter MAX_PEND, 4, maximum outstanding long-latency ops (load/MUL/DIV); PW = clog2(MAX_PEND+1).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- resultSrcE  in  2  E-stage result source; 2'b01 = load.
- branchTakenE  in  1  taken branch/jump resolved in E.
- rdE  in  RW  E-stage destination.
- issueLongE  in  1  long-latency op in E accepted by memory/MDU this cycle.
- rs1D, rs2D, rdD  in  RW  D-stage sources and destination.
- useRs1D, useRs2D  in  1  D instruction reads that source.
- longD  in  1  D instruction is long-latency.
- wbValid  in  1  a long op completes its writeback this cycle.
- wbRd  in  RW  completing destination.
- pc_write, stallF, stallD, flushD, flushE  out  1  pipeline controls.
- busy_vec  out  NREGS  registered scoreboard bits.
- pend_cnt  out  PW  outstanding long ops.

Function
REQ-005 SHALL compute clr[r] = wbValid & (wbRd==r), and busyEff[r] = busy[r] & !clr[r] (register-file write-through).
REQ-006 SHALL detect loadUse = (resultSrcE==2'b01) & (rdE!=0) & ((useRs1D & rdE==rs1D) | (useRs2D & rdE==rs2D)).
REQ-007 SHALL detect sbHaz = (useRs1D & busyEff[rs1D]) | (useRs2D & busyEff[rs2D]) | ((rdD!=0) & busyEff[rdD]).
REQ-008 SHALL detect fullHaz = longD & (pend_cnt==MAX_PEND) & !wbValid.
REQ-009 SHALL set stall = loadUse | sbHaz | fullHaz.
REQ-010 Without a taken branch, SHALL drive pc_write=!stall, stallF=stall, stallD=stall, flushE=stall, flushD=0.
REQ-011 With branchTakenE=1, SHALL drive pc_write=1, stallF=0, stallD=0, flushD=1, flushE=1, regardless of stall.
REQ-012 On each edge, SHALL set busy[rdE] when issueLongE & rdE!=0; SHALL clear busy[wbRd] when wbValid.
REQ-013 When set and clear hit the same register in the same cycle, set SHALL win.
REQ-014 Register 0 SHALL never be set busy; busy_vec[0] SHALL be 0 at all times.
REQ-015 pend_cnt SHALL change by +1 on (issueLongE & rdE!=0), by -1 on wbValid, and by 0 when both occur.
REQ-016 pend_cnt SHALL saturate at MAX_PEND and at 0 (no wrap); an out-of-range event SHALL be ignored.
REQ-017 All controls SHALL be combinational from the inputs and the registered state (zero-cycle latency); busy_vec/pend_cnt SHALL update one cycle after their event.

Reset
REQ-018 While rst_n=0, SHALL immediately force busy=0 and pend_cnt=0, and all counters to 0.
REQ-019 Controls SHALL evaluate from the cleared state during reset: pc_write=1 and the others 0 when no load-use or branch input is active.
REQ-020 Reset deassertion mid-operation SHALL discard all pending entries; no stale stall SHALL remain.

Configuration
REQ-021 With HAZARD_PERF_EN defined, SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
- stall_cnt increments on cycles with stall & !branchTakenE.
- flush_cnt increments on cycles with branchTakenE.
- Both wrap at 2^32 and reset to 0.
REQ-022 Without HAZARD_PERF_EN, those ports and registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-023 The shared package SHALL hold the RESULT_SRC_LOAD = 2'b01 constant and the default NREGS/MAX_PEND values.
REQ-024 The pending counter SHALL be a sub-module, sat_updown_counter (parameter width/max; ports inc, dec).

Verification
REQ-025 Load-use: resultSrcE=01, rdE=4, rs1D=4, useRs1D=1 -> pc_write=0, stallF=stallD=flushE=1, flushD=0.
REQ-026 Scoreboard: issueLongE with rdE=7; next cycle, rs2D=7 with useRs2D=1 -> stall=1 until wbValid with wbRd=7; in that wb cycle stall=0, and busy_vec[7]=0 after the edge.
REQ-027 Branch priority: stall condition active plus branchTakenE=1 -> pc_write=1, flushD=flushE=1, stallF=stallD=0.
REQ-028 Full: four issues to rd 1..4 -> pend_cnt=4; longD=1 -> stall; same cycle with wbValid=1 -> no stall, and pend_cnt stays 4 when a new issue coincides.
REQ-029 Corner cases:
- issueLongE with rdE=0 -> busy_vec unchanged, pend_cnt unchanged.
- Simultaneous set/clear of rd 9 -> busy_vec[9]=1.
- rst_n low mid-stall -> busy_vec=0 and pend_cnt=0 immediately.
REQ-030 With HAZARD_PERF_EN defined: 3 stall cycles and 2 branch cycles -> stall_cnt=3, flush_cnt=2.
